// File: rtl/fp_wb_arbiter_if.sv
// FP writeback arbiter bus: three result sources (alu, div, ld), the issue
// port for busy tracking, the register file write port and accrued flags.
// The slave modport is the arbiter; the master modport is whoever drives
// the sources and consumes the write port.
interface fp_wb_arbiter_if;
    logic        alu_valid_i, alu_ready_o;
    logic [4:0]  alu_rd_i, alu_flags_i;
    logic [31:0] alu_data_i;
    logic        div_valid_i, div_ready_o;
    logic [4:0]  div_rd_i, div_flags_i;
    logic [31:0] div_data_i;
    logic        ld_valid_i, ld_ready_o;
    logic [4:0]  ld_rd_i, ld_flags_i;
    logic [31:0] ld_data_i;
    logic        issue_valid_i;
    logic [4:0]  issue_rd_i;
    logic        fregwrite_o;
    logic [4:0]  frd_o;
    logic [31:0] writeback_data_o;
    logic [31:0] busy_o;
    logic        fflags_clr_i;
    logic [4:0]  fflags_o;

    modport slave (
        input  alu_valid_i, alu_rd_i, alu_data_i, alu_flags_i,
        input  div_valid_i, div_rd_i, div_data_i, div_flags_i,
        input  ld_valid_i, ld_rd_i, ld_data_i, ld_flags_i,
        input  issue_valid_i, issue_rd_i, fflags_clr_i,
        output alu_ready_o, div_ready_o, ld_ready_o,
        output fregwrite_o, frd_o, writeback_data_o, busy_o, fflags_o
    );

    modport master (
        output alu_valid_i, alu_rd_i, alu_data_i, alu_flags_i,
        output div_valid_i, div_rd_i, div_data_i, div_flags_i,
        output ld_valid_i, ld_rd_i, ld_data_i, ld_flags_i,
        output issue_valid_i, issue_rd_i, fflags_clr_i,
        input  alu_ready_o, div_ready_o, ld_ready_o,
        input  fregwrite_o, frd_o, writeback_data_o, busy_o, fflags_o
    );
endinterface

// File: rtl/fp_wb_arbiter.sv
// FP register file writeback arbiter. Round-robin grant among alu(0),
// div(1), ld(2); one write per cycle, one cycle of latency. Tracks a
// per-register pending-write bitmap for issue stalls.
// Optional accrued exception flags register: define FP_WB_FFLAGS_EN.
module fp_wb_arbiter (
    input  logic clk_i,
    input  logic rst_i,
    fp_wb_arbiter_if.slave bus
);
    logic [2:0]  vld;
    logic [2:0]  gnt;
    logic        xfer;
    logic [1:0]  ptr_q, ptr_d;
    logic [4:0]  sel_rd, sel_flags;
    logic [31:0] sel_data;
    logic        fregwrite_q;
    logic [4:0]  frd_q;
    logic [31:0] data_q;
    logic [31:0] busy_q, busy_d;

    assign vld  = {bus.ld_valid_i, bus.div_valid_i, bus.alu_valid_i};
    assign xfer = |gnt;

    // Round-robin pick starting at ptr_q; nothing is granted during reset.
    always_comb begin
        gnt = 3'b000;
        if (!rst_i) begin
            case (ptr_q)
                2'd0: begin
                    if      (vld[0]) gnt = 3'b001;
                    else if (vld[1]) gnt = 3'b010;
                    else if (vld[2]) gnt = 3'b100;
                end
                2'd1: begin
                    if      (vld[1]) gnt = 3'b010;
                    else if (vld[2]) gnt = 3'b100;
                    else if (vld[0]) gnt = 3'b001;
                end
                default: begin
                    if      (vld[2]) gnt = 3'b100;
                    else if (vld[0]) gnt = 3'b001;
                    else if (vld[1]) gnt = 3'b010;
                end
            endcase
        end
    end

    assign bus.alu_ready_o = gnt[0];
    assign bus.div_ready_o = gnt[1];
    assign bus.ld_ready_o  = gnt[2];

    // Winner's payload and the pointer position just past the winner.
    always_comb begin
        sel_rd    = bus.alu_rd_i;
        sel_data  = bus.alu_data_i;
        sel_flags = bus.alu_flags_i;
        ptr_d     = 2'd1;
        if (gnt[1]) begin
            sel_rd    = bus.div_rd_i;
            sel_data  = bus.div_data_i;
            sel_flags = bus.div_flags_i;
            ptr_d     = 2'd2;
        end else if (gnt[2]) begin
            sel_rd    = bus.ld_rd_i;
            sel_data  = bus.ld_data_i;
            sel_flags = bus.ld_flags_i;
            ptr_d     = 2'd0;
        end
    end

    // Pending-write bitmap: clear on writeback, then set on issue so a
    // same-register collision leaves the bit set.
    always_comb begin
        busy_d = busy_q;
        if (xfer)
            busy_d[sel_rd] = 1'b0;
        if (bus.issue_valid_i)
            busy_d[bus.issue_rd_i] = 1'b1;
    end

    // Write port, pointer and busy state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fregwrite_q <= 1'b0;
            frd_q       <= 5'd0;
            data_q      <= 32'd0;
            ptr_q       <= 2'd0;
            busy_q      <= 32'd0;
        end else begin
            fregwrite_q <= xfer;
            busy_q      <= busy_d;
            if (xfer) begin
                frd_q  <= sel_rd;
                data_q <= sel_data;
                ptr_q  <= ptr_d;
            end
        end
    end

    assign bus.fregwrite_o      = fregwrite_q;
    assign bus.frd_o            = frd_q;
    assign bus.writeback_data_o = data_q;
    assign bus.busy_o           = busy_q;

`ifdef FP_WB_FFLAGS_EN
    logic [4:0] fflags_q;

    // Sticky flags: a clear drops old history but keeps this edge's flags.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            fflags_q <= 5'd0;
        else
            fflags_q <= (bus.fflags_clr_i ? 5'd0 : fflags_q) |
                        (xfer ? sel_flags : 5'd0);
    end

    assign bus.fflags_o = fflags_q;
`else
    logic unused_flags;

    assign bus.fflags_o = 5'd0;
    assign unused_flags = ^{sel_flags, bus.fflags_clr_i};
`endif
endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Directed bench for fp_wb_arbiter with a scoreboard of expected write-port,
// busy and flags values, one entry per clock edge.
module tb_fp_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_wb_arbiter_if bus();

    fp_wb_arbiter dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic        wr;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] busy;
        logic [4:0]  ff;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    int          m_ptr  = 0;
    logic [31:0] m_busy = '0;
    logic [4:0]  m_ff   = '0;
    logic [4:0]  m_rd   = '0;
    logic [31:0] m_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // At the negedge: check outputs against the entry for the last edge,
    // check ready against the round-robin model, push the entry for the
    // coming edge. Returns 1 time unit after that edge.
    task automatic cycle();
        exp_t        e;
        logic [2:0]  v, g;
        int          w;
        logic [4:0]  rds[3];
        logic [4:0]  fs[3];
        logic [31:0] ds[3];
        @(negedge clk);
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("fregwrite", {31'd0, bus.fregwrite_o}, {31'd0, e.wr});
            chk("frd",       {27'd0, bus.frd_o},       {27'd0, e.rd});
            chk("wbdata",    bus.writeback_data_o,     e.data);
            chk("busy",      bus.busy_o,               e.busy);
            chk("fflags",    {27'd0, bus.fflags_o},    {27'd0, e.ff});
        end
        v   = {bus.ld_valid_i, bus.div_valid_i, bus.alu_valid_i};
        rds = '{bus.alu_rd_i, bus.div_rd_i, bus.ld_rd_i};
        ds  = '{bus.alu_data_i, bus.div_data_i, bus.ld_data_i};
        fs  = '{bus.alu_flags_i, bus.div_flags_i, bus.ld_flags_i};
        w   = -1;
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                int s;
                s = (m_ptr + i) % 3;
                if (w < 0 && v[s]) w = s;
            end
        end
        g = (w < 0) ? 3'b000 : (3'b001 << w);
        chk("ready", {29'd0, bus.ld_ready_o, bus.div_ready_o, bus.alu_ready_o}, {29'd0, g});
        if (rst) begin
            m_ptr = 0; m_busy = '0; m_ff = '0; m_rd = '0; m_data = '0;
            e.wr = 1'b0;
        end else begin
            e.wr = (w >= 0);
`ifdef FP_WB_FFLAGS_EN
            if (bus.fflags_clr_i) m_ff = '0;
            if (w >= 0) m_ff = m_ff | fs[w];
`endif
            if (w >= 0) begin
                m_rd         = rds[w];
                m_data       = ds[w];
                m_busy[m_rd] = 1'b0;
                m_ptr        = (w + 1) % 3;
            end
            if (bus.issue_valid_i) m_busy[bus.issue_rd_i] = 1'b1;
        end
        e.rd = m_rd; e.data = m_data; e.busy = m_busy; e.ff = m_ff;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.alu_valid_i = 0; bus.alu_rd_i = 0; bus.alu_data_i = 0; bus.alu_flags_i = 0;
        bus.div_valid_i = 0; bus.div_rd_i = 0; bus.div_data_i = 0; bus.div_flags_i = 0;
        bus.ld_valid_i  = 0; bus.ld_rd_i  = 0; bus.ld_data_i  = 0; bus.ld_flags_i  = 0;
        bus.issue_valid_i = 0; bus.issue_rd_i = 0; bus.fflags_clr_i = 0;
        rst = 1'b1;
        cycle(); cycle();
        rst = 1'b0;

        // Lone alu result.
        bus.alu_valid_i = 1; bus.alu_rd_i = 5'd3; bus.alu_data_i = 32'h3F80_0000;
        cycle();
        bus.alu_valid_i = 0;
        cycle(); cycle();

        // All three valid from reset: alu, div, ld, alu, div, ld.
        rst = 1'b1; cycle(); rst = 1'b0;
        bus.alu_valid_i = 1; bus.alu_rd_i = 5'd1; bus.alu_data_i = 32'hA1A1_0001;
        bus.div_valid_i = 1; bus.div_rd_i = 5'd2; bus.div_data_i = 32'hD2D2_0002;
        bus.ld_valid_i  = 1; bus.ld_rd_i  = 5'd4; bus.ld_data_i  = 32'h1D1D_0004;
        repeat (6) cycle();
        bus.alu_valid_i = 0; bus.div_valid_i = 0; bus.ld_valid_i = 0;
        cycle();

        // Issue rd 7, div writes it back four edges later.
        bus.issue_valid_i = 1; bus.issue_rd_i = 5'd7;
        cycle();
        bus.issue_valid_i = 0;
        cycle(); cycle(); cycle();
        bus.div_valid_i = 1; bus.div_rd_i = 5'd7; bus.div_data_i = 32'h4000_0000;
        cycle();
        bus.div_valid_i = 0;
        cycle();

        // Issue and writeback to rd 5 at the same edge: bit stays set.
        bus.issue_valid_i = 1; bus.issue_rd_i = 5'd5;
        bus.ld_valid_i = 1; bus.ld_rd_i = 5'd5; bus.ld_data_i = 32'h5555_5555;
        cycle();
        bus.issue_valid_i = 0; bus.ld_valid_i = 0;
        cycle();
        bus.ld_valid_i = 1; bus.ld_data_i = 32'h6666_6666;
        cycle();
        bus.ld_valid_i = 0;
        cycle();

        // f0 is an ordinary register; write to a non-busy register.
        bus.alu_valid_i = 1; bus.alu_rd_i = 5'd0; bus.alu_data_i = 32'hDEAD_BEEF;
        cycle();
        bus.alu_valid_i = 0;
        cycle();

        // Accrued flags: set, then clear together with a new transfer.
        bus.alu_valid_i = 1; bus.alu_rd_i = 5'd9; bus.alu_data_i = 32'h1; bus.alu_flags_i = 5'b00001;
        cycle();
        bus.alu_valid_i = 0; bus.alu_flags_i = 0;
        bus.div_valid_i = 1; bus.div_rd_i = 5'd10; bus.div_data_i = 32'h2; bus.div_flags_i = 5'b10000;
        bus.fflags_clr_i = 1;
        cycle();
        bus.div_valid_i = 0; bus.div_flags_i = 0; bus.fflags_clr_i = 0;
        cycle();
        bus.fflags_clr_i = 1;
        cycle();
        bus.fflags_clr_i = 0;
        cycle();

        // Reset arriving with a pending transfer and a busy register.
        bus.issue_valid_i = 1; bus.issue_rd_i = 5'd12;
        bus.alu_valid_i = 1; bus.alu_rd_i = 5'd11; bus.alu_data_i = 32'h1111_0000;
        cycle();
        bus.issue_valid_i = 0; bus.alu_valid_i = 0;
        bus.div_valid_i = 1; bus.div_rd_i = 5'd13; bus.div_data_i = 32'hBAD0_BAD0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        bus.alu_valid_i = 1; bus.ld_valid_i = 1;
        cycle(); cycle(); cycle();
        bus.alu_valid_i = 0; bus.div_valid_i = 0; bus.ld_valid_i = 0;
        cycle(); cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fp_wb_arbiter.md
FP_WB_ARBITER -- requirements
Module: fp_wb_arbiter

Interface
REQ-001 Parameters: none.
REQ-002 clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 rst_i  in  1  reset, synchronous, active-high.
REQ-004 alu_valid_i/alu_ready_o  in/out  1/1  FP ALU result handshake (source 0).
REQ-005 alu_rd_i, alu_data_i, alu_flags_i  in  5/32/5  FP ALU destination, result, exception flags.
REQ-006 div_valid_i/div_ready_o  in/out  1/1  FDIV/FSQRT result handshake (source 1).
REQ-007 div_rd_i, div_data_i, div_flags_i  in  5/32/5  FDIV/FSQRT destination, result, flags.
REQ-008 ld_valid_i/ld_ready_o  in/out  1/1  FP load (FLW) data handshake (source 2).
REQ-009 ld_rd_i, ld_data_i, ld_flags_i  in  5/32/5  FLW destination, data, flags (normally 0).
REQ-010 issue_valid_i, issue_rd_i  in  1/5  FP op with FP destination issued this cycle.
REQ-011 fregwrite_o, frd_o, writeback_data_o  out  1/5/32  FP register file write port.
REQ-012 busy_o  out  32  per-register pending-write bitmap for issue hazard stall.
REQ-013 fflags_clr_i, fflags_o  in/out  1/5  sticky accrued-flags clear / value.

Function
REQ-014 Transfer on source s occurs at a rising edge where s_valid_i=1 and s_ready_o=1; at most one transfer per cycle.
REQ-015 Sources hold valid, rd, data, flags stable until transfer; valid is not withdrawn before transfer.
REQ-016 Grant is round-robin: search order starts at pointer ptr (0=alu, 1=div, 2=ld), first valid source wins; s_ready_o=1 only for the winner.
REQ-017 After a transfer from source k, ptr becomes (k+1) mod 3; with no transfer, ptr is unchanged.
REQ-018 s_ready_o is combinational from the valids and ptr; it does not depend on any ready input (no downstream backpressure).
REQ-019 Latency is one cycle: a transfer at edge N drives fregwrite_o=1, frd_o=rd, writeback_data_o=data for exactly cycle N+1.
REQ-020 With no transfer at edge N, fregwrite_o=0 in cycle N+1; frd_o and writeback_data_o hold their last values.
REQ-021 rd=0 is written like any other register (FP f0 is not hardwired to zero).
REQ-022 busy_o[issue_rd_i] is set at the edge where issue_valid_i=1.
REQ-023 busy_o[rd] is cleared at the edge of a transfer to rd.
REQ-024 If a set and a clear hit the same rd at the same edge, set wins (busy stays 1).
REQ-025 Issue to a busy rd leaves it set; single outstanding write per rd is the issuer's responsibility.
REQ-026 A transfer to a non-busy rd is legal and leaves the bit at 0.
REQ-027 Under sustained valid from all three sources, grants cycle alu, div, ld, alu, ...; no source waits more than 2 cycles.

Reset
REQ-028 While rst_i=1 at an edge: fregwrite_o=0, frd_o=0, writeback_data_o=0, busy_o=0, fflags_o=0, ptr=0.
REQ-029 While rst_i=1, all s_ready_o=0 and no transfer occurs.
REQ-030 A transfer in flight when reset asserts is discarded; its write does not appear after reset.

Configuration
REQ-031 Macro FP_WB_FFLAGS_EN controls the accrued-flags register.
REQ-032 With FP_WB_FFLAGS_EN defined, fflags_o |= flags of each transfer at its edge, and fflags_clr_i=1 clears fflags_o.
REQ-033 With FP_WB_FFLAGS_EN defined, a clear and a transfer at the same edge load fflags_o with exactly the transferred flags.
REQ-034 Without FP_WB_FFLAGS_EN, fflags_o=0 constantly, *_flags_i and fflags_clr_i are ignored, and all ports remain present.

Verification
REQ-035 Only alu_valid_i with rd=3, data=0x3F800000 -> alu_ready_o=1 same cycle; next cycle fregwrite_o=1, frd_o=3, writeback_data_o=0x3F800000.
REQ-036 All three valid for 6 cycles from reset -> grant order alu, div, ld, alu, div, ld; six consecutive write cycles.
REQ-037 Issue rd=7, then div transfer to rd=7 four cycles later -> busy_o[7] is 1 for four cycles, then 0.
REQ-038 Issue rd=5 and ld transfer to rd=5 at the same edge -> busy_o[5] remains 1.
REQ-039 FFLAGS_EN defined: alu flags 5'b00001, then div flags 5'b10000 with fflags_clr_i=1 at that edge -> fflags_o=5'b00001, then 5'b10000.
REQ-040 rst_i asserted in the same cycle as a transfer -> next cycle fregwrite_o=0, busy_o=0, ptr=0.
